// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared defaults, data word type and pointer helper for sync_fifo
package sync_fifo_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 8;

  typedef logic [DATA_W_DEF-1:0] word_t;

  // Depth is a power of two, so masking gives the modulo wrap.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
    return (ptr + 32'd1) & (depth - 32'd1);
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - enabled modulo-DEPTH up-counter with synchronous active-high reset
module fifo_ptr
  import sync_fifo_pkg::*;
#(
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] ptr_o
);

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = ADDR_W'(next_ptr(32'(ptr_q), DEPTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered read data; SYNC_FIFO_COUNT_EN adds the COUNT port
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              EN,
  input  logic              WR,
  input  logic              RD,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] dataOut,
  output logic              EMPTY,
  output logic              FULL
`ifdef SYNC_FIFO_COUNT_EN
  ,
  output logic [ADDR_W:0]   COUNT
`endif
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] dout_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_d;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign EMPTY = (count_q == '0);
  assign FULL  = (count_q == (ADDR_W+1)'(DEPTH));

  // Full/empty come from the pre-edge count, so a full FIFO never takes a write
  // and an empty one never bypasses the incoming word to dataOut.
  assign do_wr = !Rst && EN && WR && !FULL;
  assign do_rd = !Rst && EN && RD && !EMPTY;

  fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk_i (Clk),
    .rst_i (Rst),
    .inc_i (do_wr),
    .ptr_o (wr_ptr)
  );

  fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk_i (Clk),
    .rst_i (Rst),
    .inc_i (do_rd),
    .ptr_o (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= dataIn;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_rd) begin
        dout_q <= mem[rd_ptr];
      end
    end
  end

  assign dataOut = dout_q;

`ifdef SYNC_FIFO_COUNT_EN
  assign COUNT = count_q;
`else
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - directed plus random checks of sync_fifo against a queue model
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int DEPTH = DEPTH_DEF;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        EN = 1'b0;
  logic        WR = 1'b0;
  logic        RD = 1'b0;
  word_t       dataIn = '0;
  word_t       dataOut;
  logic        EMPTY;
  logic        FULL;
`ifdef SYNC_FIFO_COUNT_EN
  logic [3:0]  COUNT;
`endif

  sync_fifo dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .EN      (EN),
    .WR      (WR),
    .RD      (RD),
    .dataIn  (dataIn),
    .dataOut (dataOut),
    .EMPTY   (EMPTY),
    .FULL    (FULL)
`ifdef SYNC_FIFO_COUNT_EN
    ,
    .COUNT   (COUNT)
`endif
  );

  always #5 Clk = ~Clk;

  word_t model_q[$];
  word_t model_out = '0;
  int    n_assert = 0;
  int    n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, then compare all outputs.
  task automatic step(input logic rst, input logic en, input logic wr, input logic rd,
                      input word_t din, input string tag);
    bit was_full, was_empty;
    Rst = rst; EN = en; WR = wr; RD = rd; dataIn = din;
    @(posedge Clk);
    #1;
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    if (rst) begin
      model_q.delete();
      model_out = '0;
    end else if (en) begin
      if (rd && !was_empty) model_out = model_q.pop_front();
      if (wr && !was_full)  model_q.push_back(din);
    end
    check({tag, ".dout"},  dataOut, model_out);
    check({tag, ".empty"}, 32'(EMPTY), 32'(model_q.size() == 0));
    check({tag, ".full"},  32'(FULL),  32'(model_q.size() == DEPTH));
`ifdef SYNC_FIFO_COUNT_EN
    check({tag, ".count"}, 32'(COUNT), 32'(model_q.size()));
`endif
  endtask

  initial begin
    // Reset
    step(1, 1, 0, 0, '0, "reset");
    check("reset.dout_zero", dataOut, 32'h0);
    check("reset.empty_one", 32'(EMPTY), 32'd1);

    // Write then read
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, word_t'(i), "wr5");
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 1, '0, "rd5");
      check("rd5.value", dataOut, 32'(i));
    end
    check("rd5.empty_after", 32'(EMPTY), 32'd1);
    for (int i = 0; i < 2; i++) step(0, 1, 0, 1, '0, "rd_extra");
    check("rd_extra.hold4", dataOut, 32'h4);

    // Fill and overflow
    for (int i = 0; i < 8; i++) step(0, 1, 1, 0, word_t'(32'h10 + i), "fill");
    check("fill.full", 32'(FULL), 32'd1);
    step(0, 1, 1, 0, 32'h99, "overflow");
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 1, '0, "drain");
      check("drain.value", dataOut, 32'h10 + 32'(i));
    end

    // Enable gating
    step(0, 1, 1, 0, 32'hA5, "pre_gate");
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 32'hDEAD0000 + 32'(i), "gate");
    step(0, 1, 0, 1, '0, "post_gate");
    check("post_gate.value", dataOut, 32'hA5);

    // Simultaneous read/write across the pointer wrap
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, word_t'(32'h100 + i), "sim_pre");
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 1, 1, word_t'(32'h103 + i), "sim");
      check("sim.order", dataOut, 32'h100 + 32'(i));
    end
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, '0, "sim_drain");
    step(0, 1, 1, 1, 32'hBEEF, "rdwr_empty");
    check("rdwr_empty.nobypass", dataOut, 32'h10E);
    step(0, 1, 0, 1, '0, "rdwr_empty_rd");
    check("rdwr_empty.value", dataOut, 32'hBEEF);

    // Mid-operation reset
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, word_t'(32'h200 + i), "pre_rst");
    step(1, 1, 1, 1, 32'h777, "mid_rst");
    check("mid_rst.dout", dataOut, 32'h0);
    step(0, 1, 0, 1, '0, "post_rst_rd");
    check("post_rst_rd.dout", dataOut, 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) != 0),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, synchronous first-in/first-out buffer for 32-bit data words, used between producer and consumer stages in the processing datapath.
- Provides registered read data and EMPTY/FULL status flags.
- A global enable gates all state changes.
- Overflowing writes and underflowing reads are silently dropped.

Parameters:
- DATA_W, 32, data word width in bits.
- DEPTH, 8, number of storage entries; must be a power of two and at least 2.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- Clk  input  1  rising-edge clock for all state.
- Rst  input  1  synchronous, active-high reset; sampled on rising Clk; overrides EN.
- EN  input  1  global enable; when 0, no state changes (except reset).
- WR  input  1  write request; dataIn is pushed on the rising edge when EN=1 and not FULL.
- RD  input  1  read request; the head word is popped to dataOut on the rising edge when EN=1 and not EMPTY.
- dataIn  input  DATA_W  write data.
- dataOut  output  DATA_W  registered read data.
- EMPTY  output  1  high when occupancy is 0.
- FULL  output  1  high when occupancy equals DEPTH.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clock port Clk, reset port Rst).
- Reset (Rst=1 at a rising Clk edge):
  - wr_ptr, rd_ptr and count all clear to 0.
  - dataOut clears to 0, EMPTY=1, FULL=0.
  - Storage array contents are not cleared.
  - Reset during any operation discards all stored words; pending WR/RD on that edge are ignored.
- State: wr_ptr[ADDR_W-1:0], rd_ptr[ADDR_W-1:0], count[ADDR_W:0].
  - EMPTY = (count==0) and FULL = (count==DEPTH), decoded from registers only.
  - No combinational path from any input to any output.
- EN=0: pointers, count, storage and dataOut all hold; WR and RD are ignored.
- Write (EN=1, WR=1, FULL=0): mem[wr_ptr] <= dataIn; wr_ptr increments modulo DEPTH.
- Write while FULL: dropped, no state change, even if RD is asserted on the same edge.
- Read (EN=1, RD=1, EMPTY=0): dataOut <= mem[rd_ptr]; rd_ptr increments modulo DEPTH.
  - Read latency is one clock: the word is visible on dataOut after the edge where RD was sampled.
- Read while EMPTY: dropped, dataOut holds its previous value.
  - No bypass: with RD and WR together when EMPTY, only the write occurs.
- Simultaneous valid read and write: both occur and count is unchanged.
  - Otherwise count increments by 1 on a valid write and decrements by 1 on a valid read.
- Pointer wrap-around is natural binary overflow of ADDR_W bits. Ordering is preserved across the wrap.
- dataOut holds its value indefinitely between valid reads.

Optional Feature:
- Macro SYNC_FIFO_COUNT_EN.
- When defined: adds output port COUNT [ADDR_W:0] carrying the registered occupancy. It is 0 after reset and updates on the same edge as the flags.
- When undefined: the port is absent. The count register still exists internally for flag generation.

Decomposition:
- Package sync_fifo_pkg holds:
  - the default DATA_W/DEPTH localparams;
  - a typedef for the data word;
  - a function computing the next pointer with wrap.
- One sub-module, fifo_ptr: an enabled modulo-DEPTH up-counter with synchronous reset. It is instantiated twice, once for the write pointer and once for the read pointer.
- Storage stays in the top as a register array.

Test Plan:
1. Reset: Rst=1 with EN=1 for 1 cycle -> EMPTY=1, FULL=0, dataOut=0x00000000.
2. Write then read: WR=1 with dataIn=0,1,2,3,4 on 5 edges, then WR=0, RD=1.
   - During writes: EMPTY falls after the first write; FULL stays 0.
   - During reads: dataOut=0,1,2,3,4 on consecutive edges; EMPTY=1 after the 5th read.
   - Extra reads leave dataOut=4.
3. Fill and overflow: write 0x10..0x17 -> FULL=1 after the 8th write.
   - Write 0x99 is dropped.
   - Eight reads return 0x10..0x17 and never 0x99.
4. Enable gating: EN=0 with WR=1 and RD=1 for 4 cycles -> count, flags and dataOut unchanged. With EN=1 afterwards, normal operation resumes.
5. Simultaneous and wrap: hold occupancy at 3 while issuing RD+WR for 12 cycles -> FULL/EMPTY stay 0 and data returns in order across the pointer wrap.
   - RD+WR when EMPTY -> only the write lands; the next read returns that word.
6. Mid-operation reset: after 5 writes, pulse Rst=1 -> EMPTY=1, dataOut=0.
   - A following read yields no new data.
   - With SYNC_FIFO_COUNT_EN defined, COUNT=0.
